csi2tx_p2b_ctrl: RTL

Per-line sequencer for the pixel-to-byte (p2b) converters in the CSI-2 TX datapath. It decodes the packet data type and drives exactly one converter enable. It registers sensor pixels and generates the aligned pixel_cnt, pixel_data_d1 and end-of-line falling-edge strobe that the converters consume. At line end it computes the long-packet byte word count and flags a done pulse to the packet header builder.

---
 rtl/csi2tx_p2b_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/csi2tx_p2b_ctrl.sv
// Per-line sequencer for the CSI-2 TX pixel-to-byte converters: converter select, pixel alignment and word count.
// Optional macro CSI2TX_P2B_LINE_LEN_CHECK_EN enables the line-length check that drives len_err.
module csi2tx_p2b_ctrl #(
  parameter int PIX_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       data_type,
  input  logic             line_start,
  input  logic             sensor_pixel_vld,
  input  logic [PIX_W-1:0] sensor_pixel_data,
  input  logic [CNT_W-1:0] exp_pixels,
  output logic [PIX_W-1:0] pixel_data,
  output logic [PIX_W-1:0] pixel_data_d1,
  output logic             pixel_data_vld,
  output logic [3:0]       pixel_cnt,
  output logic             sensor_pixel_vld_falling_edge,
  output logic             rgb565_convrn_enable,
  output logic             rgb666_convrn_enable,
  output logic             rgb888_convrn_enable,
  output logic             raw8_convrn_enable,
  output logic             raw10_convrn_enable,
  output logic [CNT_W-1:0] word_count,
  output logic             line_done,
  output logic             dt_err,
  output logic             len_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  localparam logic [5:0] DT_RGB565 = 6'h22;
  localparam logic [5:0] DT_RGB666 = 6'h23;
  localparam logic [5:0] DT_RGB888 = 6'h24;
  localparam logic [5:0] DT_RAW8   = 6'h2A;
  localparam logic [5:0] DT_RAW10  = 6'h2B;

  localparam int WC_W = CNT_W + 5;

  // Enable vector order: {rgb565, rgb666, rgb888, raw8, raw10}
  function automatic logic [4:0] dt_to_en(input logic [5:0] dt);
    case (dt)
      DT_RGB565: dt_to_en = 5'b10000;
      DT_RGB666: dt_to_en = 5'b01000;
      DT_RGB888: dt_to_en = 5'b00100;
      DT_RAW8:   dt_to_en = 5'b00010;
      DT_RAW10:  dt_to_en = 5'b00001;
      default:   dt_to_en = 5'b00000;
    endcase
  endfunction

  function automatic logic [3:0] dt_last_slot(input logic [5:0] dt);
    case (dt)
      DT_RGB565: dt_last_slot = 4'd1;
      DT_RGB666: dt_last_slot = 4'd15;
      default:   dt_last_slot = 4'd3;
    endcase
  endfunction

  logic [1:0]       state_reg;
  logic [5:0]       dt_reg;
  logic [4:0]       en_reg;
  logic [3:0]       slot_reg;
  logic [CNT_W-1:0] pix_total_reg;
  logic [PIX_W-1:0] pixel_data_reg;
  logic [PIX_W-1:0] pixel_data_d1_reg;
  logic             pixel_data_vld_reg;
  logic [3:0]       pixel_cnt_reg;
  logic             falling_edge_reg;
  logic [CNT_W-1:0] word_count_reg;
  logic             line_done_reg;
  logic             dt_err_reg;

  logic             dt_in_ok;
  logic             accept;
  logic [WC_W-1:0]  n_ext;
  logic [WC_W-1:0]  wc_calc;
  logic [CNT_W-1:0] wc_sat;

  assign dt_in_ok = (dt_to_en(data_type) != 5'b00000);

  // An unsupported re-arm in ARM drops the line, so that cycle's pixel is not taken.
  assign accept = sensor_pixel_vld &&
                  ((state_reg == ST_ACTIVE) ||
                   ((state_reg == ST_ARM) && !(line_start && !dt_in_ok)));

  // Bytes per line = ceil(pixels * bpp / 8), built from shifts and adds only.
  assign n_ext = WC_W'(pix_total_reg);
  always_comb begin
    wc_calc = '0;
    case (dt_reg)
      DT_RGB565: wc_calc = n_ext << 1;
      DT_RGB666: wc_calc = ((n_ext << 3) + n_ext + WC_W'(3)) >> 2;
      DT_RGB888: wc_calc = (n_ext << 1) + n_ext;
      DT_RAW8:   wc_calc = n_ext;
      DT_RAW10:  wc_calc = ((n_ext << 2) + n_ext + WC_W'(3)) >> 2;
      default:   wc_calc = '0;
    endcase
  end
  assign wc_sat = (|wc_calc[WC_W-1:CNT_W]) ? '1 : wc_calc[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      dt_reg             <= '0;
      en_reg             <= '0;
      slot_reg           <= '0;
      pix_total_reg      <= '0;
      pixel_data_reg     <= '0;
      pixel_data_d1_reg  <= '0;
      pixel_data_vld_reg <= 1'b0;
      pixel_cnt_reg      <= '0;
      falling_edge_reg   <= 1'b0;
      word_count_reg     <= '0;
      line_done_reg      <= 1'b0;
      dt_err_reg         <= 1'b0;
    end else begin
      pixel_data_vld_reg <= 1'b0;
      falling_edge_reg   <= 1'b0;
      line_done_reg      <= 1'b0;
      dt_err_reg         <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_ARM: begin
          if (line_start) begin
            if (dt_in_ok) begin
              dt_reg    <= data_type;
              en_reg    <= dt_to_en(data_type);
              state_reg <= ST_ARM;
            end else begin
              dt_err_reg <= 1'b1;
              en_reg     <= '0;
              state_reg  <= ST_IDLE;
            end
          end
          if (accept) begin
            state_reg <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!sensor_pixel_vld) begin
            falling_edge_reg <= 1'b1;
            pixel_cnt_reg    <= slot_reg;
            state_reg        <= ST_FLUSH;
          end
        end
        default: begin
          line_done_reg  <= 1'b1;
          word_count_reg <= wc_sat;
          pixel_cnt_reg  <= '0;
          slot_reg       <= '0;
          pix_total_reg  <= '0;
          en_reg         <= '0;
          state_reg      <= ST_IDLE;
        end
      endcase

      if (accept) begin
        pixel_data_reg     <= sensor_pixel_data;
        pixel_data_d1_reg  <= pixel_data_reg;
        pixel_data_vld_reg <= 1'b1;
        pixel_cnt_reg      <= slot_reg;
        slot_reg           <= (slot_reg == dt_last_slot(dt_reg)) ? 4'd0 : slot_reg + 4'd1;
        pix_total_reg      <= (&pix_total_reg) ? pix_total_reg : pix_total_reg + CNT_W'(1);
      end
    end
  end

`ifdef CSI2TX_P2B_LINE_LEN_CHECK_EN
  logic len_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err_reg <= 1'b0;
    end else begin
      len_err_reg <= (state_reg == ST_FLUSH) && (pix_total_reg != exp_pixels);
    end
  end

  assign len_err = len_err_reg;
`else
  logic unused_exp_pixels;

  assign unused_exp_pixels = ^exp_pixels;
  assign len_err           = 1'b0;
`endif

  assign pixel_data                    = pixel_data_reg;
  assign pixel_data_d1                 = pixel_data_d1_reg;
  assign pixel_data_vld                = pixel_data_vld_reg;
  assign pixel_cnt                     = pixel_cnt_reg;
  assign sensor_pixel_vld_falling_edge = falling_edge_reg;
  assign rgb565_convrn_enable          = en_reg[4];
  assign rgb666_convrn_enable          = en_reg[3];
  assign rgb888_convrn_enable          = en_reg[2];
  assign raw8_convrn_enable            = en_reg[1];
  assign raw10_convrn_enable           = en_reg[0];
  assign word_count                    = word_count_reg;
  assign line_done                     = line_done_reg;
  assign dt_err                        = dt_err_reg;

endmodule
